// File: rtl/alu_ctrl_seq_if.sv
// Decode request / decoded-result bundle between the issue stage and alu_ctrl_seq.
// The master side (issue stage) drives the decode request. The slave side (alu_ctrl_seq)
// returns the ready signal, the decoded ALU controls and the MDU sequencing status.
//   in_valid, alu_op, funct           : request from issue stage / main control
//   in_ready                          : request accepted when in_valid & in_ready
//   out_valid, alu_ctrl, jump_reg,
//   shamt_var, hilo_rd, illegal       : registered decode results
//   mdu_start, mdu_op, mdu_busy       : multiply/divide launch and occupancy
interface alu_ctrl_seq_if #(
  parameter int unsigned CTRL_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        alu_op;
  logic [5:0]        funct;
  logic              out_valid;
  logic [CTRL_W-1:0] alu_ctrl;
  logic              jump_reg;
  logic              shamt_var;
  logic              mdu_start;
  logic [1:0]        mdu_op;
  logic              hilo_rd;
  logic              illegal;
  logic              mdu_busy;

  modport master (
    output in_valid, alu_op, funct,
    input  in_ready, out_valid, alu_ctrl, jump_reg, shamt_var, mdu_start, mdu_op,
           hilo_rd, illegal, mdu_busy
  );

  modport slave (
    input  in_valid, alu_op, funct,
    output in_ready, out_valid, alu_ctrl, jump_reg, shamt_var, mdu_start, mdu_op,
           hilo_rd, illegal, mdu_busy
  );
endinterface

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decoder with a multiply/divide busy sequencer (execute stage).
// Decodes alu_op/funct into an ALU control code, jr flag and shift-source select, launches
// the MDU on mult/div and stalls MDU-dependent requests (mfhi/mflo/mthi/mtlo/mult/div)
// while the MDU is occupied. All decoded outputs are registered (latency 1).
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_ctrl_seq_if.slave (request, ready, decoded outputs, MDU status)
// Build option: define ALU_CTRL_VARSHIFT_EN to decode sllv/srlv/srav (funct 4/6/7)
// as variable shifts; otherwise they are illegal and shamt_var stays 0.
module alu_ctrl_seq #(
  parameter int unsigned CTRL_W     = 4,
  parameter int unsigned MDU_CYCLES = 32,
  parameter int unsigned CNT_W      = 8
) (
  input logic           clk,
  input logic           rst_n,
  alu_ctrl_seq_if.slave bus
);

  localparam logic [CTRL_W-1:0] CodeAnd  = CTRL_W'(0);
  localparam logic [CTRL_W-1:0] CodeOr   = CTRL_W'(1);
  localparam logic [CTRL_W-1:0] CodeAdd  = CTRL_W'(2);
  localparam logic [CTRL_W-1:0] CodeXor  = CTRL_W'(3);
  localparam logic [CTRL_W-1:0] CodeSub  = CTRL_W'(6);
  localparam logic [CTRL_W-1:0] CodeSlt  = CTRL_W'(7);
  localparam logic [CTRL_W-1:0] CodeSltu = CTRL_W'(8);
  localparam logic [CTRL_W-1:0] CodeNor  = CTRL_W'(12);
  localparam logic [CTRL_W-1:0] CodeSll  = CTRL_W'(13);
  localparam logic [CTRL_W-1:0] CodeSrl  = CTRL_W'(14);
  localparam logic [CTRL_W-1:0] CodeSra  = CTRL_W'(15);

  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_jr, dec_shv, dec_start, dec_hilo, dec_ill;
  logic [1:0]        dec_op;
  logic              hazard, accept;

  logic [CTRL_W-1:0] alu_ctrl_q, alu_ctrl_d;
  logic              jump_reg_q, jump_reg_d;
  logic              shamt_var_q, shamt_var_d;
  logic              hilo_rd_q, hilo_rd_d;
  logic              illegal_q, illegal_d;
  logic [1:0]        mdu_op_q, mdu_op_d;
  logic              out_valid_q, out_valid_d;
  logic              mdu_start_q, mdu_start_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;

  always_comb begin
    dec_ctrl  = CodeAnd;
    dec_jr    = 1'b0;
    dec_shv   = 1'b0;
    dec_start = 1'b0;
    dec_op    = 2'd0;
    dec_hilo  = 1'b0;
    dec_ill   = 1'b0;
    unique case (bus.alu_op)
      2'd0: dec_ctrl = CodeAdd;
      2'd1: dec_ctrl = CodeSub;
      2'd3: dec_ctrl = CodeAnd;
      default: begin
        case (bus.funct)
          6'd36:        dec_ctrl = CodeAnd;
          6'd37:        dec_ctrl = CodeOr;
          6'd32, 6'd33: dec_ctrl = CodeAdd;
          6'd34, 6'd35: dec_ctrl = CodeSub;
          6'd38:        dec_ctrl = CodeXor;
          6'd42:        dec_ctrl = CodeSlt;
          6'd43:        dec_ctrl = CodeSltu;
          6'd39:        dec_ctrl = CodeNor;
          6'd0:         dec_ctrl = CodeSll;
          6'd2:         dec_ctrl = CodeSrl;
          6'd3:         dec_ctrl = CodeSra;
`ifdef ALU_CTRL_VARSHIFT_EN
          6'd4: begin dec_ctrl = CodeSll; dec_shv = 1'b1; end
          6'd6: begin dec_ctrl = CodeSrl; dec_shv = 1'b1; end
          6'd7: begin dec_ctrl = CodeSra; dec_shv = 1'b1; end
`endif
          6'd8: begin
            dec_ctrl = CodeAdd;
            dec_jr   = 1'b1;
          end
          6'd16, 6'd18: begin
            dec_ctrl = CodeAdd;
            dec_hilo = 1'b1;
          end
          6'd17, 6'd19: dec_ctrl = CodeAdd;
          6'd24, 6'd25, 6'd26, 6'd27: begin
            dec_ctrl  = CodeAdd;
            dec_start = 1'b1;
            dec_op    = bus.funct[1:0];  // funct - 24
          end
          default: dec_ill = 1'b1;
        endcase
      end
    endcase
  end

  // Requests touching HI/LO or the MDU itself must wait for the MDU to drain.
  always_comb begin
    hazard = 1'b0;
    if (bus.alu_op == 2'd2) begin
      hazard = (bus.funct[5:2] == 4'b0100) || (bus.funct[5:2] == 4'b0110);
    end
  end

  assign bus.in_ready = ~(busy_q & hazard);
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    alu_ctrl_d  = alu_ctrl_q;
    jump_reg_d  = jump_reg_q;
    shamt_var_d = shamt_var_q;
    hilo_rd_d   = hilo_rd_q;
    illegal_d   = illegal_q;
    mdu_op_d    = mdu_op_q;
    out_valid_d = accept;
    mdu_start_d = accept & dec_start;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    if (accept) begin
      alu_ctrl_d  = dec_ctrl;
      jump_reg_d  = dec_jr;
      shamt_var_d = dec_shv;
      hilo_rd_d   = dec_hilo;
      illegal_d   = dec_ill;
      mdu_op_d    = dec_op;
    end
    // Busy stays high through the cycle where the counter sits at zero.
    if (accept && dec_start) begin
      cnt_d  = CNT_W'(MDU_CYCLES - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (cnt_q == '0) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_ctrl_q  <= '0;
      jump_reg_q  <= 1'b0;
      shamt_var_q <= 1'b0;
      hilo_rd_q   <= 1'b0;
      illegal_q   <= 1'b0;
      mdu_op_q    <= 2'd0;
      out_valid_q <= 1'b0;
      mdu_start_q <= 1'b0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      alu_ctrl_q  <= alu_ctrl_d;
      jump_reg_q  <= jump_reg_d;
      shamt_var_q <= shamt_var_d;
      hilo_rd_q   <= hilo_rd_d;
      illegal_q   <= illegal_d;
      mdu_op_q    <= mdu_op_d;
      out_valid_q <= out_valid_d;
      mdu_start_q <= mdu_start_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.alu_ctrl  = alu_ctrl_q;
  assign bus.jump_reg  = jump_reg_q;
  assign bus.shamt_var = shamt_var_q;
  assign bus.hilo_rd   = hilo_rd_q;
  assign bus.illegal   = illegal_q;
  assign bus.mdu_op    = mdu_op_q;
  assign bus.out_valid = out_valid_q;
  assign bus.mdu_start = mdu_start_q;
  assign bus.mdu_busy  = busy_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: directed scenarios plus random requests, all checked
// against a behavioural model (decode table + "MDU busy until N cycles after launch").
module tb_alu_ctrl_seq;
  localparam int unsigned CTRL_W     = 4;
  localparam int unsigned MDU_CYCLES = 4;
  localparam int unsigned CNT_W      = 8;

  typedef struct packed {
    logic [3:0] ctrl;
    logic       jr;
    logic       shv;
    logic       start;
    logic [1:0] op;
    logic       hilo;
    logic       ill;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  exp_t held;
  bit   mdu_have;
  int   mdu_edge;

  alu_ctrl_seq_if #(.CTRL_W(CTRL_W)) bus ();

  alu_ctrl_seq #(
    .CTRL_W    (CTRL_W),
    .MDU_CYCLES(MDU_CYCLES),
    .CNT_W     (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Decode table straight from the instruction-set rules.
  function automatic exp_t ref_decode(input logic [1:0] op, input logic [5:0] fn);
    exp_t e;
    int   f;
    e = '0;
    f = int'(fn);
    if (op == 2'd0) e.ctrl = 4'd2;
    else if (op == 2'd1) e.ctrl = 4'd6;
    else if (op == 2'd3) e.ctrl = 4'd0;
    else begin
      case (f)
        36: e.ctrl = 4'd0;
        37: e.ctrl = 4'd1;
        32, 33: e.ctrl = 4'd2;
        34, 35: e.ctrl = 4'd6;
        38: e.ctrl = 4'd3;
        42: e.ctrl = 4'd7;
        43: e.ctrl = 4'd8;
        39: e.ctrl = 4'd12;
        0: e.ctrl = 4'd13;
        2: e.ctrl = 4'd14;
        3: e.ctrl = 4'd15;
`ifdef ALU_CTRL_VARSHIFT_EN
        4: begin e.ctrl = 4'd13; e.shv = 1'b1; end
        6: begin e.ctrl = 4'd14; e.shv = 1'b1; end
        7: begin e.ctrl = 4'd15; e.shv = 1'b1; end
`endif
        8: begin e.ctrl = 4'd2; e.jr = 1'b1; end
        16, 18: begin e.ctrl = 4'd2; e.hilo = 1'b1; end
        17, 19: e.ctrl = 4'd2;
        24, 25, 26, 27: begin
          e.ctrl  = 4'd2;
          e.start = 1'b1;
          e.op    = 2'(f - 24);
        end
        default: e.ill = 1'b1;
      endcase
    end
    return e;
  endfunction

  function automatic bit model_busy();
    return mdu_have && ((cyc - mdu_edge) < int'(MDU_CYCLES));
  endfunction

  // One clock of stimulus: check ready before the edge, all outputs after it.
  task automatic step(input logic v, input logic [1:0] op, input logic [5:0] fn,
                      output bit acc);
    bit   haz, rdy;
    exp_t d;
    bus.in_valid = v;
    bus.alu_op   = op;
    bus.funct    = fn;
    #1;
    haz = (op == 2'd2) && ((fn >= 16 && fn <= 19) || (fn >= 24 && fn <= 27));
    rdy = !(model_busy() && haz);
    checks++;
    if (bus.in_ready !== rdy) begin
      errors++;
      $display("FAIL in_ready op=%0d funct=%0d got %b want %b", op, fn, bus.in_ready, rdy);
    end
    acc = v && rdy;
    d   = ref_decode(op, fn);
    @(posedge clk);
    #1;
    if (acc) begin
      held = d;
      if (d.start) begin
        mdu_have = 1'b1;
        mdu_edge = cyc;
      end
    end
    checks++;
    if (bus.out_valid !== acc) begin
      errors++;
      $display("FAIL out_valid funct=%0d got %b want %b", fn, bus.out_valid, acc);
    end
    checks++;
    if (bus.mdu_start !== (acc && d.start)) begin
      errors++;
      $display("FAIL mdu_start funct=%0d got %b want %b", fn, bus.mdu_start, acc && d.start);
    end
    if (acc && d.start) begin
      checks++;
      if (bus.mdu_op !== d.op) begin
        errors++;
        $display("FAIL mdu_op funct=%0d got %0d want %0d", fn, bus.mdu_op, d.op);
      end
    end
    checks++;
    if (bus.mdu_busy !== model_busy()) begin
      errors++;
      $display("FAIL mdu_busy cyc=%0d got %b want %b", cyc, bus.mdu_busy, model_busy());
    end
    checks++;
    if ({bus.alu_ctrl, bus.jump_reg, bus.shamt_var, bus.hilo_rd, bus.illegal} !==
        {held.ctrl, held.jr, held.shv, held.hilo, held.ill}) begin
      errors++;
      $display("FAIL decode op=%0d funct=%0d got ctrl=%0d jr=%b shv=%b hilo=%b ill=%b want ctrl=%0d jr=%b shv=%b hilo=%b ill=%b",
               op, fn, bus.alu_ctrl, bus.jump_reg, bus.shamt_var, bus.hilo_rd, bus.illegal,
               held.ctrl, held.jr, held.shv, held.hilo, held.ill);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 6'd0, a);
  endtask

  task automatic check_cleared(input string name);
    checks++;
    if ({bus.out_valid, bus.alu_ctrl, bus.jump_reg, bus.shamt_var, bus.mdu_start, bus.mdu_op,
         bus.hilo_rd, bus.illegal, bus.mdu_busy} !== '0) begin
      errors++;
      $display("FAIL %s outputs not cleared: valid=%b ctrl=%0d jr=%b shv=%b start=%b op=%0d hilo=%b ill=%b busy=%b",
               name, bus.out_valid, bus.alu_ctrl, bus.jump_reg, bus.shamt_var, bus.mdu_start,
               bus.mdu_op, bus.hilo_rd, bus.illegal, bus.mdu_busy);
    end
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.alu_op   = 2'd2;
    bus.funct    = 6'd18;
    held         = '0;
    mdu_have     = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_cleared("reset");
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit a;
    step(1'b1, 2'd2, 6'd37, a);
    step(1'b1, 2'd1, 6'd37, a);
    step(1'b1, 2'd0, 6'd8, a);
    step(1'b1, 2'd3, 6'd42, a);
    step(1'b1, 2'd2, 6'd43, a);
    idle(2);
  endtask

  task automatic test_jr();
    bit a;
    step(1'b1, 2'd2, 6'd8, a);
    step(1'b1, 2'd2, 6'd42, a);
    step(1'b1, 2'd2, 6'd63, a);
  endtask

  task automatic test_mdu_stall();
    bit a;
    int stalls;
    step(1'b1, 2'd2, 6'd24, a);
    stalls = 0;
    a      = 1'b0;
    for (int i = 0; i < 20 && !a; i++) begin
      step(1'b1, 2'd2, 6'd18, a);
      if (!a) stalls++;
    end
    checks++;
    if (!a || stalls != int'(MDU_CYCLES)) begin
      errors++;
      $display("FAIL mfhi_stall accepted=%b stalls=%0d want %0d", a, stalls, MDU_CYCLES);
    end
  endtask

  task automatic test_overlap();
    bit a;
    step(1'b1, 2'd2, 6'd27, a);
    step(1'b1, 2'd2, 6'd32, a);
    checks++;
    if (!a) begin
      errors++;
      $display("FAIL overlap_add got stalled want accepted");
    end
    step(1'b1, 2'd2, 6'd26, a);
    checks++;
    if (a) begin
      errors++;
      $display("FAIL overlap_div got accepted want stalled");
    end
    idle(int'(MDU_CYCLES));
  endtask

  task automatic test_varshift();
    bit a;
    step(1'b1, 2'd2, 6'd6, a);
    step(1'b1, 2'd2, 6'd4, a);
    step(1'b1, 2'd2, 6'd2, a);
    step(1'b1, 2'd2, 6'd7, a);
  endtask

  task automatic test_reset_mid();
    bit a;
    step(1'b1, 2'd2, 6'd26, a);
    idle(2);
    #2;
    rst_n    = 1'b0;
    held     = '0;
    mdu_have = 1'b0;
    #1;
    check_cleared("reset_mid");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 2'd2, 6'd16, a);
    checks++;
    if (!a) begin
      errors++;
      $display("FAIL post_reset_mfhi got stalled want accepted");
    end
  endtask

  task automatic test_random();
    bit         a;
    logic [5:0] fn;
    logic [1:0] op;
    logic       v;
    for (int i = 0; i < 300; i++) begin
      v  = ($urandom_range(0, 9) < 8);
      op = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd2;
      if ($urandom_range(0, 3) == 0) fn = 6'($urandom_range(0, 63));
      else begin
        case ($urandom_range(0, 7))
          0: fn = 6'd18;
          1: fn = 6'd16;
          2: fn = 6'($urandom_range(24, 27));
          3: fn = 6'($urandom_range(32, 43));
          4: fn = 6'($urandom_range(0, 8));
          5: fn = 6'($urandom_range(17, 19));
          default: fn = 6'd37;
        endcase
      end
      step(v, op, fn, a);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_jr();
    test_mdu_stall();
    test_overlap();
    test_varshift();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
